// File: rtl/mm_port_bank.sv
`default_nettype none
// ============================================================================
// Module   : mm_port_bank
// Purpose  : Memory-mapped bank of PORT_COUNT one-word buffered I/O ports.
//            Sits behind the address decode/translate stage. Thread reads
//            drain the inbound buffer of the addressed port, and thread
//            writes fill its outbound buffer. An access to an empty inbound
//            or a full outbound buffer raises a same-cycle stall so the
//            pipeline can annul and retry the instruction.
// Ports    : clock, reset_n          - clock, async active-low reset
//            in_range, port_address  - decoder hit and zero-based port index
//            read_enable/write_enable/write_data - thread request
//            read_data/read_valid    - registered read response (1-cycle pulse)
//            stall, stall_count      - combinational stall, saturating count
//            port_in_*               - inbound valid/ready channel per port
//            port_out_*              - outbound valid/ready channel per port
// Revision : 1.0 - initial release
// ============================================================================
module mm_port_bank #(
  parameter int PORT_COUNT        = 4,
  parameter int PORT_ADDR_WIDTH   = 2,
  parameter int WORD_WIDTH        = 36,
  parameter int STALL_COUNT_WIDTH = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             in_range,
  input  logic [PORT_ADDR_WIDTH-1:0]       port_address,
  input  logic                             read_enable,
  input  logic                             write_enable,
  input  logic [WORD_WIDTH-1:0]            write_data,
  output logic [WORD_WIDTH-1:0]            read_data,
  output logic                             read_valid,
  output logic                             stall,
  output logic [STALL_COUNT_WIDTH-1:0]     stall_count,
  input  logic [PORT_COUNT*WORD_WIDTH-1:0] port_in_data,
  input  logic [PORT_COUNT-1:0]            port_in_valid,
  output logic [PORT_COUNT-1:0]            port_in_ready,
  output logic [PORT_COUNT*WORD_WIDTH-1:0] port_out_data,
  output logic [PORT_COUNT-1:0]            port_out_valid,
  input  logic [PORT_COUNT-1:0]            port_out_ready
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WORD_WIDTH-1:0]        in_buf_q  [PORT_COUNT];
  logic [WORD_WIDTH-1:0]        in_buf_d  [PORT_COUNT];
  logic [WORD_WIDTH-1:0]        out_buf_q [PORT_COUNT];
  logic [WORD_WIDTH-1:0]        out_buf_d [PORT_COUNT];
  logic [PORT_COUNT-1:0]        in_full_q;
  logic [PORT_COUNT-1:0]        in_full_d;
  logic [PORT_COUNT-1:0]        out_full_q;
  logic [PORT_COUNT-1:0]        out_full_d;
  logic [WORD_WIDTH-1:0]        read_data_q;
  logic [WORD_WIDTH-1:0]        read_data_d;
  logic                         read_valid_q;
  logic                         read_valid_d;
  logic [STALL_COUNT_WIDTH-1:0] stall_count_q;
  logic [STALL_COUNT_WIDTH-1:0] stall_count_d;

  // --------------------------------------------------------------------------
  // Per-port combinational terms
  // --------------------------------------------------------------------------
  logic [PORT_COUNT-1:0] port_sel;    // access is live and targets port p
  logic [PORT_COUNT-1:0] rd_take;     // thread read completes on port p
  logic [PORT_COUNT-1:0] wr_take;     // thread write completes on port p
  logic [PORT_COUNT-1:0] in_accept;   // inbound handshake on port p
  logic [PORT_COUNT-1:0] out_drain;   // outbound handshake on port p

  logic read_stall;
  logic write_stall;
  logic [WORD_WIDTH-1:0] rd_word;

  // The per-port decode doubles as the range check: an index at or beyond
  // PORT_COUNT matches no port, so the access is simply ignored.
  genvar p;
  generate
    for (p = 0; p < PORT_COUNT; p++) begin : g_port
      assign port_sel[p]  = in_range && (port_address == PORT_ADDR_WIDTH'(p));
      assign rd_take[p]   = read_enable  && port_sel[p] &&  in_full_q[p];
      assign wr_take[p]   = write_enable && port_sel[p] && !out_full_q[p];
      assign in_accept[p] = port_in_valid[p]  && !in_full_q[p];
      assign out_drain[p] = port_out_ready[p] &&  out_full_q[p];

      assign port_in_ready[p]                          = !in_full_q[p];
      assign port_out_valid[p]                         = out_full_q[p];
      assign port_out_data[p*WORD_WIDTH +: WORD_WIDTH] = out_buf_q[p];

      // Fill and drain of one buffer need opposite flag values, so they can
      // never coincide on the same port and need no priority.
      always_comb begin
        in_full_d[p] = in_full_q[p];
        in_buf_d[p]  = in_buf_q[p];
        if (in_accept[p]) begin
          in_full_d[p] = 1'b1;
          in_buf_d[p]  = port_in_data[p*WORD_WIDTH +: WORD_WIDTH];
        end else if (rd_take[p]) begin
          in_full_d[p] = 1'b0;
        end
      end

      // out_buf keeps its last word after the drain; only the flag clears.
      always_comb begin
        out_full_d[p] = out_full_q[p];
        out_buf_d[p]  = out_buf_q[p];
        if (wr_take[p]) begin
          out_full_d[p] = 1'b1;
          out_buf_d[p]  = write_data;
        end else if (out_drain[p]) begin
          out_full_d[p] = 1'b0;
        end
      end
    end
  endgenerate

  // Stall looks only at registered flags, never at the port handshakes, so a
  // same-cycle fill or drain does not rescue the access.
  assign read_stall  = read_enable  && |(port_sel & ~in_full_q);
  assign write_stall = write_enable && |(port_sel &  out_full_q);
  assign stall       = read_stall || write_stall;

  // At most one port_sel bit is set, so an OR-mux is sufficient.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (port_sel[i]) begin
        rd_word = rd_word | in_buf_q[i];
      end
    end
  end

  // read_data holds its last value between reads.
  always_comb begin
    read_data_d  = read_data_q;
    read_valid_d = |rd_take;
    if (|rd_take) begin
      read_data_d = rd_word;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {STALL_COUNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_full_q     <= '0;
      out_full_q    <= '0;
      read_data_q   <= '0;
      read_valid_q  <= 1'b0;
      stall_count_q <= '0;
      for (int i = 0; i < PORT_COUNT; i++) begin
        in_buf_q[i]  <= '0;
        out_buf_q[i] <= '0;
      end
    end else begin
      in_full_q     <= in_full_d;
      out_full_q    <= out_full_d;
      read_data_q   <= read_data_d;
      read_valid_q  <= read_valid_d;
      stall_count_q <= stall_count_d;
      for (int i = 0; i < PORT_COUNT; i++) begin
        in_buf_q[i]  <= in_buf_d[i];
        out_buf_q[i] <= out_buf_d[i];
      end
    end
  end

  assign read_data   = read_data_q;
  assign read_valid  = read_valid_q;
  assign stall_count = stall_count_q;

endmodule
`default_nettype wire
